// File: rtl/commit_stage_pkg.sv
// Shared types for the commit stage: execute-result record, commit FSM states, field helpers.
package commit_stage_pkg;

    localparam int CAUSE_W = 5;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;
    typedef logic [63:0] uint64_t;
    typedef logic [4:0]  reg_idx_t;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        TRAP_WAIT = 2'd1,
        TRET_WAIT = 2'd2
    } commit_state_e;

    typedef struct packed {
        logic reg_write;
        logic fp_reg_write;
    } op_t;

    typedef struct packed {
        logic               valid;
        logic [CAUSE_W-1:0] cause;
        word_t              value;
    } trap_info_t;

    // One execute result; the stage register holds exactly this record.
    typedef struct packed {
        logic       valid;
        addr_t      pc;
        word_t      insn;
        op_t        op;
        word_t      dst_int_reg_value;
        uint64_t    dst_fp_reg_value;
        logic       branch_taken;
        addr_t      branch_target;
        trap_info_t trap_info;
        logic       trap_return;
    } exec_result_t;

    function automatic reg_idx_t insn_rd(input word_t insn);
        return insn[11:7];
    endfunction

endpackage

// File: rtl/retire_counter.sv
// 64-bit retired-instruction counter; increments by one per enabled cycle, wraps modulo 2^64.
module retire_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/commit_stage.sv
// Final pipeline stage: registers one execute result, writes register files, redirects fetch,
// and runs the trap / trap-return handshake with the CSR unit.
module commit_stage
    import commit_stage_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  exec_result_t       prev_i,
    output logic               busy_o,
    output logic               int_reg_write_enable_o,
    output logic [4:0]         int_reg_write_addr_o,
    output logic [31:0]        int_reg_write_value_o,
    output logic               fp_reg_write_enable_o,
    output logic [4:0]         fp_reg_write_addr_o,
    output logic [63:0]        fp_reg_write_value_o,
    output logic               redirect_valid_o,
    output logic [31:0]        redirect_pc_o,
    output logic               flush_o,
    output logic               trap_req_o,
    output logic [CAUSE_W-1:0] trap_cause_o,
    output logic [31:0]        trap_value_o,
    output logic [31:0]        trap_pc_o,
    output logic               trap_return_req_o,
    input  logic               csr_trap_ack_i,
    input  logic [31:0]        csr_trap_vector_i,
    input  logic               csr_trap_return_ack_i,
    input  logic [31:0]        csr_epc_i,
    output logic [63:0]        instret_o
);

    commit_state_e state_q, state_d;
    exec_result_t  r_q;
    logic          retire;
    logic          unused_insn_bits;

    assign unused_insn_bits = ^{r_q.insn[31:12], r_q.insn[6:0]};
    assign busy_o = (state_q != NORMAL);

    always_comb begin
        state_d                = state_q;
        retire                 = 1'b0;
        int_reg_write_enable_o = 1'b0;
        int_reg_write_addr_o   = insn_rd(r_q.insn);
        int_reg_write_value_o  = r_q.dst_int_reg_value;
        fp_reg_write_enable_o  = 1'b0;
        fp_reg_write_addr_o    = insn_rd(r_q.insn);
        fp_reg_write_value_o   = r_q.dst_fp_reg_value;
        redirect_valid_o       = 1'b0;
        redirect_pc_o          = '0;
        flush_o                = 1'b0;
        trap_req_o             = 1'b0;
        trap_cause_o           = '0;
        trap_value_o           = '0;
        trap_pc_o              = '0;
        trap_return_req_o      = 1'b0;

        unique case (state_q)
            NORMAL: begin
                if (r_q.valid) begin
                    if (r_q.trap_info.valid) begin
                        flush_o = 1'b1;
                        state_d = TRAP_WAIT;
                    end else if (r_q.trap_return) begin
                        flush_o = 1'b1;
                        retire  = 1'b1;
                        state_d = TRET_WAIT;
                    end else begin
                        // Taken branches still write rd so jal/jalr links land.
                        int_reg_write_enable_o = r_q.op.reg_write && (insn_rd(r_q.insn) != 5'd0);
                        fp_reg_write_enable_o  = r_q.op.fp_reg_write;
                        retire                 = 1'b1;
                        if (r_q.branch_taken) begin
                            redirect_valid_o = 1'b1;
                            redirect_pc_o    = r_q.branch_target;
                            flush_o          = 1'b1;
                        end
                    end
                end
            end
            TRAP_WAIT: begin
                trap_req_o   = 1'b1;
                trap_cause_o = r_q.trap_info.cause;
                trap_value_o = r_q.trap_info.value;
                trap_pc_o    = r_q.pc;
                if (csr_trap_ack_i) begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = csr_trap_vector_i;
                    flush_o          = 1'b1;
                    state_d          = NORMAL;
                end
            end
            TRET_WAIT: begin
                trap_return_req_o = 1'b1;
                if (csr_trap_return_ack_i) begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = csr_epc_i;
                    flush_o          = 1'b1;
                    state_d          = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase

        // A reset cycle must never steer fetch, even if an ack lands in it.
        if (rst_i) begin
            redirect_valid_o = 1'b0;
            flush_o          = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= NORMAL;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == NORMAL) begin
                // Only valid is cleared so a trapping record keeps its cause/value/pc.
                if (flush_o) begin
                    r_q.valid <= 1'b0;
                end else begin
                    r_q <= prev_i;
                end
            end
        end
    end

    retire_counter u_retire_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (retire),
        .count_o (instret_o)
    );

endmodule

// File: tb/tb_commit_stage.sv
// Directed per-cycle vectors for commit_stage plus hand-written reset sequences.
module tb_commit_stage;
    import commit_stage_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        iwe;
        logic [4:0]  iaddr;
        logic [31:0] ival;
        logic        fwe;
        logic [4:0]  faddr;
        logic [63:0] fval;
        logic        rv;
        logic [31:0] rpc;
        logic        flush;
        logic        treq;
        logic [4:0]  tcause;
        logic [31:0] tval;
        logic [31:0] tpc;
        logic        tret;
        logic [63:0] instret;
    } out_t;

    typedef struct {
        exec_result_t p;
        logic         tack;
        logic [31:0]  tvec;
        logic         rack;
        logic [31:0]  epc;
        out_t         e;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    exec_result_t       prev;
    logic               busy, iwe, fwe, rv, flush, treq, tret;
    logic [4:0]         iaddr, faddr;
    logic [31:0]        ival, rpc, tval, tpc;
    logic [63:0]        fval, instret;
    logic [CAUSE_W-1:0] tcause;
    logic               tack, rack;
    logic [31:0]        tvec, epc;

    int applied = 0;
    int miscompares = 0;
    vec_t tbl[20];

    always #5 clk = ~clk;

    commit_stage dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .prev_i                 (prev),
        .busy_o                 (busy),
        .int_reg_write_enable_o (iwe),
        .int_reg_write_addr_o   (iaddr),
        .int_reg_write_value_o  (ival),
        .fp_reg_write_enable_o  (fwe),
        .fp_reg_write_addr_o    (faddr),
        .fp_reg_write_value_o   (fval),
        .redirect_valid_o       (rv),
        .redirect_pc_o          (rpc),
        .flush_o                (flush),
        .trap_req_o             (treq),
        .trap_cause_o           (tcause),
        .trap_value_o           (tval),
        .trap_pc_o              (tpc),
        .trap_return_req_o      (tret),
        .csr_trap_ack_i         (tack),
        .csr_trap_vector_i      (tvec),
        .csr_trap_return_ack_i  (rack),
        .csr_epc_i              (epc),
        .instret_o              (instret)
    );

    function automatic exec_result_t ins(addr_t pc, reg_idx_t rd, logic rw, logic fw,
                                         word_t iv, uint64_t fv);
        exec_result_t x = '0;
        x.valid             = 1'b1;
        x.pc                = pc;
        x.insn              = {20'h0, rd, 7'h13};
        x.op.reg_write      = rw;
        x.op.fp_reg_write   = fw;
        x.dst_int_reg_value = iv;
        x.dst_fp_reg_value  = fv;
        return x;
    endfunction

    function automatic out_t base(logic b, logic [63:0] ir);
        out_t o = '0;
        o.busy    = b;
        o.instret = ir;
        return o;
    endfunction

    function automatic out_t w_int(out_t o, logic [4:0] a, logic [31:0] v);
        o.iwe = 1'b1; o.iaddr = a; o.ival = v;
        return o;
    endfunction

    function automatic out_t w_fp(out_t o, logic [4:0] a, logic [63:0] v);
        o.fwe = 1'b1; o.faddr = a; o.fval = v;
        return o;
    endfunction

    function automatic out_t w_flush(out_t o);
        o.flush = 1'b1;
        return o;
    endfunction

    function automatic out_t w_redir(out_t o, logic [31:0] pc);
        o.rv = 1'b1; o.rpc = pc; o.flush = 1'b1;
        return o;
    endfunction

    function automatic out_t w_treq(out_t o, logic [4:0] c, logic [31:0] v, logic [31:0] pc);
        o.treq = 1'b1; o.tcause = c; o.tval = v; o.tpc = pc;
        return o;
    endfunction

    function automatic out_t w_tret(out_t o);
        o.tret = 1'b1;
        return o;
    endfunction

    function automatic vec_t mk(exec_result_t p, logic ta, logic [31:0] tv,
                                logic ra, logic [31:0] ep, out_t e);
        vec_t v;
        v.p = p; v.tack = ta; v.tvec = tv; v.rack = ra; v.epc = ep; v.e = e;
        return v;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.busy = busy; o.iwe = iwe; o.iaddr = iaddr; o.ival = ival;
        o.fwe = fwe; o.faddr = faddr; o.fval = fval;
        o.rv = rv; o.rpc = rpc; o.flush = flush;
        o.treq = treq; o.tcause = tcause; o.tval = tval; o.tpc = tpc;
        o.tret = tret; o.instret = instret;
        return o;
    endfunction

    // Address/data fields are only meaningful while their qualifier is expected high.
    function automatic logic match(out_t a, out_t e);
        logic ok;
        ok = (a.busy === e.busy) && (a.iwe === e.iwe) && (a.fwe === e.fwe) &&
             (a.rv === e.rv) && (a.flush === e.flush) && (a.treq === e.treq) &&
             (a.tret === e.tret) && (a.instret === e.instret);
        if (e.iwe)  ok = ok && (a.iaddr === e.iaddr) && (a.ival === e.ival);
        if (e.fwe)  ok = ok && (a.faddr === e.faddr) && (a.fval === e.fval);
        if (e.rv)   ok = ok && (a.rpc === e.rpc);
        if (e.treq) ok = ok && (a.tcause === e.tcause) && (a.tval === e.tval) && (a.tpc === e.tpc);
        return ok;
    endfunction

    task automatic check(input string name, input out_t e);
        out_t a;
        a = observe();
        applied++;
        if (!match(a, e)) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, a, e);
        end
    endtask

    task automatic drive(input exec_result_t p, input logic ta, input logic [31:0] tv,
                         input logic ra, input logic [31:0] ep);
        prev = p; tack = ta; tvec = tv; rack = ra; epc = ep;
    endtask

    initial begin
        exec_result_t nop, br, trp, trt, trp2;
        out_t         zero_o;
        out_t         a;
        logic [31:0]  dbf;

        nop    = '0;
        zero_o = '0;
        dbf    = 32'hDEAD_BEEF;

        br = ins(32'h8000_0004, 5'd1, 1'b1, 1'b0, 32'h8000_0008, 64'h0);
        br.branch_taken  = 1'b1;
        br.branch_target = 32'h8000_0100;

        trp = ins(32'h200, 5'd3, 1'b1, 1'b0, 32'h33, 64'h0);
        trp.branch_taken    = 1'b1;
        trp.branch_target   = 32'h999;
        trp.trap_info.valid = 1'b1;
        trp.trap_info.cause = 5'd2;
        trp.trap_info.value = dbf;

        trt = ins(32'h300, 5'd4, 1'b1, 1'b0, 32'h44, 64'h0);
        trt.trap_return = 1'b1;

        trp2 = ins(32'h400, 5'd2, 1'b0, 1'b0, 32'h0, 64'h0);
        trp2.trap_info.valid = 1'b1;
        trp2.trap_info.cause = 5'd7;
        trp2.trap_info.value = 32'h1;

        tbl[0]  = mk(ins(32'h0, 5'd5, 1'b1, 1'b0, 32'h11, 64'h0), 0, 0, 0, 0, base(0, 0));
        tbl[1]  = mk(ins(32'h4, 5'd0, 1'b1, 1'b0, 32'h22, 64'h0), 0, 0, 0, 0,
                     w_int(base(0, 0), 5'd5, 32'h11));
        tbl[2]  = mk(ins(32'h8, 5'd6, 1'b1, 1'b0, 32'h33, 64'h0), 0, 0, 0, 0, base(0, 1));
        tbl[3]  = mk(ins(32'hC, 5'd0, 1'b0, 1'b1, 32'h0, 64'h1122_3344_5566_7788), 0, 0, 0, 0,
                     w_int(base(0, 2), 5'd6, 32'h33));
        tbl[4]  = mk(br, 0, 0, 0, 0, w_fp(base(0, 3), 5'd0, 64'h1122_3344_5566_7788));
        tbl[5]  = mk(ins(32'h8000_0008, 5'd7, 1'b1, 1'b0, 32'h77, 64'h0), 0, 0, 0, 0,
                     w_redir(w_int(base(0, 4), 5'd1, 32'h8000_0008), 32'h8000_0100));
        tbl[6]  = mk(nop, 0, 0, 0, 0, base(0, 5));
        tbl[7]  = mk(trp, 0, 0, 0, 0, base(0, 5));
        tbl[8]  = mk(nop, 1, 32'h666, 0, 0, w_flush(base(0, 5)));
        tbl[9]  = mk(ins(32'h500, 5'd9, 1'b1, 1'b0, 32'h99, 64'h0), 0, 0, 0, 0,
                     w_treq(base(1, 5), 5'd2, dbf, 32'h200));
        tbl[10] = mk(nop, 0, 0, 1, 32'h777, w_treq(base(1, 5), 5'd2, dbf, 32'h200));
        tbl[11] = mk(nop, 0, 0, 0, 0, w_treq(base(1, 5), 5'd2, dbf, 32'h200));
        tbl[12] = mk(nop, 1, 32'h100, 0, 0,
                     w_redir(w_treq(base(1, 5), 5'd2, dbf, 32'h200), 32'h100));
        tbl[13] = mk(trt, 0, 0, 0, 0, base(0, 5));
        tbl[14] = mk(nop, 0, 0, 1, 32'h999, w_flush(base(0, 5)));
        tbl[15] = mk(nop, 1, 32'h555, 0, 0, w_tret(base(1, 6)));
        tbl[16] = mk(nop, 0, 0, 1, 32'h204, w_redir(w_tret(base(1, 6)), 32'h204));
        tbl[17] = mk(ins(32'h204, 5'd8, 1'b1, 1'b0, 32'h88, 64'h0), 0, 0, 0, 0, base(0, 6));
        tbl[18] = mk(nop, 0, 0, 0, 0, w_int(base(0, 6), 5'd8, 32'h88));
        tbl[19] = mk(nop, 0, 0, 0, 0, base(0, 7));

        // Reset held two cycles while upstream presents a valid instruction.
        rst = 1'b1;
        drive(ins(32'h40, 5'd5, 1'b1, 1'b0, 32'h55, 64'h0), 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #4;
        a = observe();
        applied++;
        if (a !== zero_o) begin
            miscompares++;
            $display("FAIL reset_outputs got %h expected %h", a, zero_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(nop, 0, 0, 0, 0);
        #4;
        check("after_reset_idle", base(0, 0));

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].p, tbl[i].tack, tbl[i].tvec, tbl[i].rack, tbl[i].epc);
            #4;
            check($sformatf("vec%0d", i), tbl[i].e);
        end

        // Reset during TRAP_WAIT with an ack in the same cycle.
        @(negedge clk);
        drive(trp2, 0, 0, 0, 0);
        @(negedge clk);
        drive(nop, 0, 0, 0, 0);
        #4;
        check("rstwait_entry", w_flush(base(0, 7)));
        @(negedge clk);
        #4;
        check("rstwait_wait", w_treq(base(1, 7), 5'd7, 32'h1, 32'h400));
        @(negedge clk);
        rst = 1'b1;
        drive(nop, 1, 32'h500, 0, 0);
        #4;
        check("rstwait_ack_cycle", w_treq(base(1, 7), 5'd7, 32'h1, 32'h400));
        @(negedge clk);
        rst = 1'b0;
        drive(nop, 0, 0, 0, 0);
        #4;
        check("rstwait_after", base(0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/commit_stage.md
# commit_stage

Final pipeline stage and the consuming end of the execute-stage interface. Registers each execute result for one cycle, then writes the integer/FP register files, issues branch and trap redirects to fetch with a pipeline flush, runs the trap/trap-return handshake with the CSR unit, and counts retired instructions.

## Interface
- No parameters. Widths come from the shared type packages: word_t/addr_t = 32, uint64_t = 64, reg index = 5.
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- prev  in  ExecuteStageIF.NextStage  fields used:
  - valid 1
  - pc 32
  - insn 32; rd = insn[11:7]
  - op.regWrite, op.fpRegWrite; 1 each
  - dstIntRegValue 32
  - dstFpRegValue 64
  - branchTaken 1
  - branchTarget 32
  - trapInfo.valid / .cause / .value
  - trapReturn 1
- busy  out  1  upstream must hold; high whenever state != NORMAL
- intRegWriteEnable  out  1
- intRegWriteAddr  out  5
- intRegWriteValue  out  32
- fpRegWriteEnable  out  1
- fpRegWriteAddr  out  5
- fpRegWriteValue  out  64
- redirectValid  out  1
- redirectPc  out  32
- flush  out  1  kill all younger in-flight instructions
- trapReq  out  1
- trapCause  out  trapInfo.cause width
- trapValue  out  32
- trapPc  out  32
- trapReturnReq  out  1
- csrTrapAck  in  1
- csrTrapVector  in  32
- csrTrapReturnAck  in  1
- csrEpc  in  32
- instret  out  64  retired-instruction count

## Operation
- Stage register R holds all prev fields. On reset: R.valid=0, state=NORMAL, instret=0, all outputs 0.
- R loads prev each cycle when state==NORMAL and flush==0. When flush==1 in NORMAL, R.valid loads 0. In the wait states R holds its contents.
- Priority for a valid R: trap > trapReturn > branch > plain.
- Plain instruction (NORMAL, R.valid, no trap):
  - intRegWriteEnable = op.regWrite && rd!=0
  - fpRegWriteEnable = op.fpRegWrite; fpRegWriteAddr = rd, including rd=0
  - instret increments by 1 the next cycle.
- Branch (branchTaken, no trap): redirectValid=1, redirectPc=branchTarget, flush=1 in the same cycle. Register writes and retire still happen (jal/jalr link).
- Trap (R.trapInfo.valid):
  - No register write, no retire.
  - flush=1 this cycle; state goes to TRAP_WAIT.
- TRAP_WAIT:
  - trapReq=1; trapCause/trapValue/trapPc are driven from R.
  - On csrTrapAck: redirectValid=1, redirectPc=csrTrapVector, flush=1, state goes to NORMAL.
- TrapReturn: flush=1 and state goes to TRET_WAIT. The instruction retires on entry to TRET_WAIT; no register write.
- TRET_WAIT: trapReturnReq=1. On csrTrapReturnAck: redirectValid=1, redirectPc=csrEpc, flush=1, state goes to NORMAL.
- Acks are ignored outside their own wait state. Acks that arrive in the entry cycle (still NORMAL) are ignored.
- instret wraps modulo 2^64.
- Reset mid-handshake: rst wins. Next cycle is NORMAL with trapReq/trapReturnReq=0, even if an ack arrives in the same cycle.

## Timing
- prev valid in cycle N means R is valid in N+1. Register writes and branch redirect in N+1 (1-cycle latency, combinational from R).
- Trap: flush in N+1, trapReq from N+2 until ack cycle M. Redirect in M, busy low from M+1.
- Minimum trap/return turnaround: ack in N+2 gives redirect in N+2.
- Redirect and flush are single-cycle pulses, except flush in the entry cycle.
- Back-to-back plain instructions: one per cycle, no bubbles.

## Structure
- Shared package (ProcessorTypes): CommitState enum {NORMAL, TRAP_WAIT, TRET_WAIT}; struct for stage register R.
- Sub-module retire_counter: 64-bit counter with increment enable and sync reset.
- Everything else stays in commit_stage.

## Test plan
- Reset: assert rst 2 cycles with prev.valid=1 -> all outputs 0, instret=0, state NORMAL.
- Stream of 3 addi writes to x5=0x11, x0=0x22, x6=0x33 -> writes to x5 and x6 only, one per cycle. The x0 write is suppressed. instret=3.
- Branch: taken with target 0x8000_0100 and a link write to x1=0x8000_0008 -> same cycle: redirect to 0x8000_0100, flush=1, x1 written. The instruction arriving next cycle is dropped.
- Trap: cause 2, value 0xDEAD_BEEF, pc 0x200, with branchTaken also set -> no branch redirect, no retire. trapReq held 4 cycles. Ack with vector 0x100 -> redirect 0x100 with flush; busy low the next cycle.
- Trap return: ack with csrEpc 0x204 after 1 wait cycle -> redirect 0x204. instret +1. Spurious csrTrapAck during TRET_WAIT is ignored.
- rst asserted during TRAP_WAIT with csrTrapAck=1 -> no redirect, trapReq=0 the next cycle, state NORMAL.
